// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and sizing helpers for the single-port bit-write SRAM model
package sram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } sram_state_t;

    function automatic int lane_count(input int bits, input int lane_width);
        return bits / lane_width;
    endfunction

    // The init counter must stay at least one bit wide even for a single-entry array.
    function automatic int init_cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sram_init_ctrl.sv
// rtl/sram_init_ctrl.sv - post-reset zero-fill sequencer: walks every entry once, then reports ready
module sram_init_ctrl
    import sram_pkg::*;
#(
    parameter int Word_Depth = 64,
    parameter int Cnt_Width  = init_cnt_width(Word_Depth)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 init_we,
    output logic [Cnt_Width-1:0] init_addr,
    output logic                 ready
);

    localparam logic [Cnt_Width-1:0] LAST = Cnt_Width'(Word_Depth - 1);

    sram_state_t          state_q, state_d;
    logic [Cnt_Width-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + Cnt_Width'(1);
                end
            end
            IDLE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign init_we   = (state_q == INIT);
    assign init_addr = cnt_q;
    assign ready     = (state_q == IDLE);

endmodule

// File: rtl/sram_1p_bwe.sv
// rtl/sram_1p_bwe.sv - parametrised single-port SRAM with per-lane write enable and zero-init after reset
// Optional build macro SRAM_RANDOMIZE_EN: Q takes random data on non-read cycles once ready.
module sram_1p_bwe
    import sram_pkg::*;
#(
    parameter int Bits       = 64,
    parameter int Word_Depth = 64,
    parameter int Add_Width  = 6,
    parameter int Lane_Width = 8
) (
    input  logic                                  CLK,
    input  logic                                  RSTB,
    input  logic                                  CEB,
    input  logic                                  WEB,
    input  logic [lane_count(Bits,Lane_Width)-1:0] BWEB,
    input  logic [Add_Width-1:0]                  A,
    input  logic [Bits-1:0]                       D,
    output logic [Bits-1:0]                       Q,
    output logic                                  READY,
    output logic                                  AERR
);

    localparam int                 LANES = lane_count(Bits, Lane_Width);
    localparam int                 CNT_W = init_cnt_width(Word_Depth);
    localparam logic [Add_Width:0] DEPTH = (Add_Width + 1)'(Word_Depth);

    if (Bits % Lane_Width != 0) begin : g_bad_lane
        $fatal(1, "sram_1p_bwe: Bits must be a multiple of Lane_Width");
    end
    if (Word_Depth > (2 ** Add_Width)) begin : g_bad_depth
        $fatal(1, "sram_1p_bwe: Word_Depth exceeds the address space");
    end

    logic             init_we;
    logic [CNT_W-1:0] init_addr;
    logic             ready;

    sram_init_ctrl #(
        .Word_Depth (Word_Depth),
        .Cnt_Width  (CNT_W)
    ) u_init_ctrl (
        .clk       (CLK),
        .rst_n     (RSTB),
        .init_we   (init_we),
        .init_addr (init_addr),
        .ready     (ready)
    );

    logic [Bits-1:0]      ram [Word_Depth];
    logic                 a_ok;
    logic                 user_acc;
    logic                 wr_en;
    logic [Add_Width-1:0] wr_addr;
    logic [Bits-1:0]      wr_data;
    logic [LANES-1:0]     wr_lane;

    assign a_ok     = ({1'b0, A} < DEPTH);
    assign user_acc = ready & ~CEB;

    // The init sequencer owns the port until ready; user inputs are ignored meanwhile.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = A;
        wr_data = D;
        wr_lane = ~BWEB;
        if (init_we) begin
            wr_en   = 1'b1;
            wr_addr = Add_Width'(init_addr);
            wr_data = '0;
            wr_lane = '1;
        end else if (user_acc && !WEB && a_ok) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_lane[i]) begin
                    ram[wr_addr][i*Lane_Width +: Lane_Width] <= wr_data[i*Lane_Width +: Lane_Width];
                end
            end
        end
    end

`ifdef SRAM_RANDOMIZE_EN
    localparam int RAND_REPS = (Bits + 31) / 32;
`endif

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            Q    <= '0;
            AERR <= 1'b0;
        end else begin
            AERR <= user_acc & ~a_ok;
            if (user_acc && WEB) begin
                Q <= a_ok ? ram[A] : '0;
            end
`ifdef SRAM_RANDOMIZE_EN
            else if (ready) begin
                Q <= Bits'({RAND_REPS{$random}});
            end
`endif
        end
    end

    assign READY = ready;

endmodule

// File: tb/tb_sram_1p_bwe.sv
// tb/tb_sram_1p_bwe.sv - bench for sram_1p_bwe: vector table, random traffic vs array model, reset sequences
module tb_sram_1p_bwe;

`ifdef SRAM_RANDOMIZE_EN
    localparam bit RAND_BUILD = 1'b1;
`else
    localparam bit RAND_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstb;
    logic        ceb;
    logic        web;
    logic [7:0]  bweb;
    logic [5:0]  a;
    logic [63:0] d;
    logic [63:0] q64, q48;
    logic        rdy64, rdy48, aerr64, aerr48;

    always #5 clk = ~clk;

    sram_1p_bwe #(.Bits(64), .Word_Depth(64), .Add_Width(6), .Lane_Width(8)) u_dut64 (
        .CLK(clk), .RSTB(rstb), .CEB(ceb), .WEB(web), .BWEB(bweb), .A(a), .D(d),
        .Q(q64), .READY(rdy64), .AERR(aerr64)
    );

    sram_1p_bwe #(.Bits(64), .Word_Depth(48), .Add_Width(6), .Lane_Width(8)) u_dut48 (
        .CLK(clk), .RSTB(rstb), .CEB(ceb), .WEB(web), .BWEB(bweb), .A(a), .D(d),
        .Q(q48), .READY(rdy48), .AERR(aerr48)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: an array per instance, a count of edges since reset release, expected Q/AERR.
    int          dep [2] = '{64, 48};
    logic [63:0] mem [2][64];
    logic [63:0] mq  [2];
    bit          mqk [2];
    bit          mae [2];
    int          cnt;

    typedef struct {
        bit          ceb;
        bit          web;
        logic [7:0]  bweb;
        logic [5:0]  a;
        logic [63:0] d;
        bit          chk;
        logic [63:0] q64;
        logic [63:0] q48;
        bit          ae64;
        bit          ae48;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        if (!rstb) begin
            cnt = 0;
            for (int k = 0; k < 2; k++) begin
                mq[k] = '0; mqk[k] = 1'b1; mae[k] = 1'b0;
                for (int i = 0; i < 64; i++) mem[k][i] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                mae[k] = 1'b0;
                if (cnt >= dep[k]) begin
                    if (!ceb && int'(a) >= dep[k]) begin
                        mae[k] = 1'b1;
                        if (web) begin mq[k] = '0; mqk[k] = 1'b1; end
                        else if (RAND_BUILD) mqk[k] = 1'b0;
                    end else if (!ceb && web) begin
                        mq[k] = mem[k][a]; mqk[k] = 1'b1;
                    end else begin
                        if (!ceb)
                            for (int l = 0; l < 8; l++)
                                if (!bweb[l]) mem[k][a][l*8 +: 8] = d[l*8 +: 8];
                        if (RAND_BUILD) mqk[k] = 1'b0;
                    end
                end
            end
            if (cnt < 100000) cnt++;
        end
    endtask

    task automatic compare_all();
        chk("ready64", {63'd0, rdy64}, {63'd0, cnt >= dep[0]});
        chk("ready48", {63'd0, rdy48}, {63'd0, cnt >= dep[1]});
        chk("aerr64", {63'd0, aerr64}, {63'd0, mae[0]});
        chk("aerr48", {63'd0, aerr48}, {63'd0, mae[1]});
        if (mqk[0]) chk("q64_model", q64, mq[0]);
        if (mqk[1]) chk("q48_model", q48, mq[1]);
    endtask

    task automatic step(input bit c, input bit w, input logic [7:0] be, input logic [5:0] ad, input logic [63:0] dd);
        ceb = c; web = w; bweb = be; a = ad; d = dd;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic rand_write();
        step(1'b0, 1'b0, 8'h00, 6'($urandom_range(63)), {$urandom, $urandom});
    endtask

    task automatic wait_ready(input bit user_writes, input string name);
        int n;
        n = 0;
        while (!rdy64 && n < 200) begin
            if (user_writes) rand_write();
            else step(1'b1, 1'b1, 8'hFF, 6'd0, 64'd0);
            n++;
        end
        chk(name, 64'(n), 64'd64);
    endtask

    task automatic sweep(input bit expect_zero64);
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 1'b1, 8'hFF, 6'(i), 64'd0);
            if (expect_zero64) chk("zero64", q64, 64'd0);
        end
    endtask

    initial begin
        // ceb web bweb a d chk q64 q48 ae64 ae48
        tbl.push_back('{1'b0, 1'b1, 8'hFF, 6'd0,  64'd0, 1'b1, 64'd0, 64'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'hFF, 6'd31, 64'd0, 1'b1, 64'd0, 64'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'hFF, 6'd63, 64'd0, 1'b1, 64'd0, 64'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 8'h00, 6'd5, 64'h1122_3344_5566_7788, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 8'hF0, 6'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'hFF, 6'd5, 64'd0, 1'b1, 64'h1122_3344_FFFF_FFFF, 64'h1122_3344_FFFF_FFFF, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 8'h00, 6'd7, 64'hA5, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'hFF, 6'd7, 64'd0, 1'b1, 64'hA5, 64'hA5, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'hFF, 6'd0, 64'd0, 1'b1, 64'd0, 64'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'hFF, 6'd7, 64'd0, 1'b1, 64'hA5, 64'hA5, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'hFF, 6'd0, 64'd0, 1'b1, 64'd0, 64'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'hFF, 6'd7, 64'd0, 1'b1, 64'hA5, 64'hA5, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 8'h00, 6'd50, 64'hDEAD, 1'b1, 64'hA5, 64'hA5, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 8'hFF, 6'd50, 64'd0, 1'b1, 64'hDEAD, 64'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 8'hFF, 6'd7, 64'hFFFF, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'hFF, 6'd7, 64'd0, 1'b1, 64'hA5, 64'hA5, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'hFF, 6'd47, 64'd0, 1'b1, 64'd0, 64'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'hFF, 6'd48, 64'd0, 1'b1, 64'd0, 64'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 8'hFE, 6'd47, 64'hFFFF_FFFF_FFFF_FF47, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'hFF, 6'd47, 64'd0, 1'b1, 64'h47, 64'h47, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 8'h00, 6'd9, 64'h5A, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'hFF, 6'd9, 64'd0, 1'b1, 64'h5A, 64'h5A, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 8'hFF, 6'd9, 64'd0, 1'b1, 64'h5A, 64'h5A, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 8'h00, 6'd9, 64'h77, 1'b1, 64'h5A, 64'h5A, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 8'hFF, 6'd9, 64'd0, 1'b1, 64'h5A, 64'h5A, 1'b0, 1'b0});

        rstb = 1'b0; ceb = 1'b1; web = 1'b1; bweb = 8'hFF; a = '0; d = '0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 6'd3, 64'hFFFF);
        chk("reset_q64", q64, 64'd0);
        rstb = 1'b1;
        wait_ready(1'b0, "ready_latency_first");

        foreach (tbl[i]) begin
            step(tbl[i].ceb, tbl[i].web, tbl[i].bweb, tbl[i].a, tbl[i].d);
            if (tbl[i].chk && !(RAND_BUILD && (tbl[i].ceb || !tbl[i].web))) begin
                chk($sformatf("vec%0d_q64", i), q64, tbl[i].q64);
                chk($sformatf("vec%0d_q48", i), q48, tbl[i].q48);
            end
            chk($sformatf("vec%0d_aerr64", i), {63'd0, aerr64}, {63'd0, tbl[i].ae64});
            chk($sformatf("vec%0d_aerr48", i), {63'd0, aerr48}, {63'd0, tbl[i].ae48});
        end
        if (RAND_BUILD) begin
            step(1'b1, 1'b1, 8'hFF, 6'd9, 64'd0);
            checks++;
            if (q64 === 64'h5A) begin
                failures++;
                $display("FAIL rand_idle_q64 actual=%h required=not 5a", q64);
            end
        end

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(3) == 0), $urandom_range(1), 8'($urandom), 6'($urandom_range(63)),
                 {$urandom, $urandom});
        end
        sweep(1'b0);

        // Reset mid-operation, then reset again in the middle of INIT with user writes driven.
        rstb = 1'b0;
        #1;
        chk("async_reset_q64", q64, 64'd0);
        chk("async_reset_ready64", {63'd0, rdy64}, 64'd0);
        @(negedge clk);
        model_edge();
        rstb = 1'b1;
        for (int i = 0; i < 20; i++) rand_write();
        rstb = 1'b0;
        step(1'b0, 1'b0, 8'h00, 6'd1, 64'hFFFF);
        rstb = 1'b1;
        wait_ready(1'b1, "ready_latency_reinit");
        sweep(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_1p_bwe.md
# sram_1p_bwe

Parametrised single-port synchronous SRAM behavioural model with per-lane bit-write enable and a hardware post-reset zero-initialisation sequencer. It replaces the fixed-geometry single-port macro models used for cache tag/data arrays: one model covers any width/depth, supports partial writes, and guarantees known contents after reset. Sits directly under cache array wrappers, in place of the foundry macro for simulation and FPGA builds.

## Interface
- Bits, 64: data word width.
- Word_Depth, 64: number of entries.
- Add_Width, 6: address width; Word_Depth <= 2**Add_Width.
- Lane_Width, 8: write-enable granularity; Bits must be a multiple of Lane_Width.
- CLK  in  1  clock; all state updates on rising edge.
- RSTB  in  1  reset, asynchronous, active-low.
- CEB  in  1  chip enable, active-low.
- WEB  in  1  write enable, active-low (0 = write, 1 = read).
- BWEB  in  Bits/Lane_Width  per-lane write enable, active-low.
- A  in  Add_Width  address.
- D  in  Bits  write data.
- Q  out  Bits  registered read data.
- READY  out  1  high when the array accepts accesses (initialisation done).
- AERR  out  1  one-cycle pulse: accepted access to an address >= Word_Depth.

## Operation
- States: INIT, IDLE. RSTB low forces INIT, counter = 0, Q = 0, READY = 0, AERR = 0.
- INIT: each cycle writes all-zero to entry counter and increments; after writing entry Word_Depth-1, moves to IDLE and sets READY = 1 on that same edge. Takes exactly Word_Depth cycles after RSTB deasserts.
- During INIT, CEB/WEB/BWEB/A/D are ignored: no user write, Q holds 0, AERR stays 0.
- IDLE, CEB=0, WEB=0: for every lane i with BWEB[i]=0, ram[A] lane i <= D lane i; lanes with BWEB[i]=1 unchanged. All-ones BWEB is a legal no-op write.
- IDLE, CEB=0, WEB=1: Q <= ram[A] (registered value before any same-edge update; a single port gives no read/write collision).
- IDLE, CEB=1: no array access; Q per Configuration.
- Write cycles: Q per Configuration (not the write data).
- Address A >= Word_Depth with CEB=0: write dropped, read returns Q = 0, AERR = 1 for one cycle.
- RSTB asserted mid-INIT or mid-operation: array contents are not modified asynchronously; on release INIT re-runs from entry 0 and the array ends all-zero.

## Timing
- Read latency 1: address sampled at edge N, data on Q after edge N.
- Write visible to a read issued on the next cycle (write at edge N, read at edge N+1 returns new data).
- READY rises Word_Depth rising edges after RSTB deasserts; first user access is accepted on the edge at which READY is sampled high.
- AERR is asserted in the cycle after the offending access, aligned with Q.

## Configuration
- SRAM_RANDOMIZE_EN defined: on non-read cycles in IDLE (CEB=1 or write), Q <= random data ({Bits} bits from $random, replicated as needed) to expose consumers that sample Q without a read.
- Not defined: Q holds its previous value on non-read cycles. Reset value, INIT behaviour, and read data are identical in both builds.

## Structure
- Shared package sram_pkg: state enum (INIT, IDLE), a lane-count function Bits/Lane_Width, and a width helper for the init counter ($clog2(Word_Depth), minimum 1).
- One sub-module, sram_init_ctrl: owns the state register and init counter; outputs init write strobe, init address, READY. The top module owns the array, the lane-masked write mux, Q, and AERR.
- Elaboration check: fatal error if Bits % Lane_Width != 0 or Word_Depth > 2**Add_Width.

## Test plan
- Reset release, Word_Depth=64 -> READY low for 64 cycles, then high; reads of entries 0, 31, 63 return 0.
- Write D=64'h1122_3344_5566_7788 to A=5 with BWEB=8'h00, then write D=64'hFFFF_FFFF_FFFF_FFFF with BWEB=8'hF0; read A=5 -> Q=64'h1122_3344_FFFF_FFFF one cycle later.
- Back-to-back write A=7 (D=64'hA5), read A=7 on the next cycle -> Q=64'hA5; alternating reads A=0/A=7 every cycle -> Q follows with latency 1.
- Word_Depth=48, Add_Width=6: write to A=50 then read A=50 -> AERR pulses once per access; Q=0; entries 0..47 unchanged.
- Drop RSTB for one cycle at init cycle 20 with user writes driven during INIT -> READY rises 64 cycles after the second release; all entries read 0.
- CEB=1 idle cycles after a read of 64'h5A -> Q stays 64'h5A without SRAM_RANDOMIZE_EN; with it, Q changes and no assertion fires.
